mc_controller: RTL and testbench

- Multicycle MIPS control FSM; successor to the single-cycle main decoder.
- Sequences a shared-memory multicycle datapath (one memory, one ALU, IR/A/B/ALUOut registers) through fetch/decode/execute/writeback.
- Adds a memory-ready handshake so fetch, load and store can stall on slow memory.
- Drives datapath muxes and enables; the ALU decoder consumes aluop.

---
 rtl/mc_controller_if.sv | 32 +++
 rtl/mc_controller.sv | 182 ++++++++++++++++++
 tb/tb_mc_controller.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// Control bus between the multicycle MIPS control FSM and its datapath.
// The controller takes the master modport; the datapath (or bench) takes the slave modport.
interface mc_controller_if;
    logic [5:0] op;
    logic       memready;
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       iord;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, memready,
        output pcwrite, branch, irwrite, iord, memwrite, regdst, memtoreg,
               regwrite, alusrca, alusrcb, pcsrc, aluop, illegal, state
    );

    modport slave (
        output op, memready,
        input  pcwrite, branch, irwrite, iord, memwrite, regdst, memtoreg,
               regwrite, alusrca, alusrcb, pcsrc, aluop, illegal, state
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with memory-ready stalls in FETCH, MEMRD and MEMWR.
// Outputs are decoded from state; only the FETCH write enables depend on memready.
module mc_controller (
    input  logic                   clk,
    input  logic                   reset,
    mc_controller_if.master        bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;
    state_t state_d;

    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       iord;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:    state_d = bus.memready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_RTYPE:      state_d = S_EXECUTE;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_ADDI:       state_d = S_ADDIEXEC;
                    OP_J:          state_d = S_JUMP;
                    default:       state_d = S_FETCH;
                endcase
            end
            // op is held by IR, so a non-memory op here can only mean corruption
            S_MEMADR: begin
                case (bus.op)
                    OP_LW:   state_d = S_MEMRD;
                    OP_SW:   state_d = S_MEMWR;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMRD:    state_d = bus.memready ? S_MEMWB : S_MEMRD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    state_d = bus.memready ? S_FETCH : S_MEMWR;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        irwrite  = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        illegal  = 1'b0;
        unique case (state_q)
            // reset masks the fetch strobes so nothing is latched while held
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = bus.memready & ~reset;
                pcwrite = bus.memready & ~reset;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (bus.op)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
                    default:                                       illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
                pcwrite = 1'b0;
            end
        endcase
    end

    assign bus.pcwrite  = pcwrite;
    assign bus.branch   = branch;
    assign bus.irwrite  = irwrite;
    assign bus.iord     = iord;
    assign bus.memwrite = memwrite;
    assign bus.regdst   = regdst;
    assign bus.memtoreg = memtoreg;
    assign bus.regwrite = regwrite;
    assign bus.alusrca  = alusrca;
    assign bus.alusrcb  = alusrcb;
    assign bus.pcsrc    = pcsrc;
    assign bus.aluop    = aluop;
    assign bus.illegal  = illegal;
    assign bus.state    = state_q;

    a_pc_exclusive: assert property (@(posedge clk) disable iff (reset) !(branch && pcwrite));

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus randomized
// instruction streams checked against a per-instruction trace model.
module tb_mc_controller;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3, ST_MEMWB = 4,
                   ST_MEMWR = 5, ST_EXECUTE = 6, ST_ALUWB = 7, ST_BRANCH = 8,
                   ST_ADDIEXEC = 9, ST_ADDIWB = 10, ST_JUMP = 11;

    logic [15:0] ctl_vec;
    assign ctl_vec = {bus.pcwrite, bus.branch, bus.irwrite, bus.iord, bus.memwrite,
                      bus.regdst, bus.memtoreg, bus.regwrite, bus.alusrca,
                      bus.alusrcb, bus.pcsrc, bus.aluop, bus.illegal};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Instruction class: 0 R, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J, -1 unsupported
    function automatic int op_kind(input logic [5:0] opv);
        case (opv)
            6'b000000: return 0;
            6'b100011: return 1;
            6'b101011: return 2;
            6'b000100: return 3;
            6'b001000: return 4;
            6'b000010: return 5;
            default:   return -1;
        endcase
    endfunction

    // Control word the datapath should see in a given state
    function automatic logic [15:0] exp_ctl(input int st, input logic mr,
                                            input logic [5:0] opv, input logic rst);
        logic pw, br, irw, iord, mw, rdst, m2r, rw, asa, ill;
        logic [1:0] asb, psrc, aop;
        {pw, br, irw, iord, mw, rdst, m2r, rw, asa, ill} = '0;
        asb = 2'd0; psrc = 2'd0; aop = 2'd0;
        case (st)
            ST_FETCH:    begin asb = 2'd1; irw = mr && !rst; pw = mr && !rst; end
            ST_DECODE:   begin asb = 2'd3; ill = (op_kind(opv) < 0); end
            ST_MEMADR:   begin asa = 1; asb = 2'd2; end
            ST_MEMRD:    iord = 1;
            ST_MEMWB:    begin m2r = 1; rw = 1; end
            ST_MEMWR:    begin iord = 1; mw = 1; end
            ST_EXECUTE:  begin asa = 1; aop = 2'd2; end
            ST_ALUWB:    begin rdst = 1; rw = 1; end
            ST_BRANCH:   begin asa = 1; aop = 2'd1; psrc = 2'd1; br = 1; end
            ST_ADDIEXEC: begin asa = 1; asb = 2'd2; end
            ST_ADDIWB:   rw = 1;
            ST_JUMP:     begin psrc = 2'd2; pw = 1; end
            default:     ;
        endcase
        return {pw, br, irw, iord, mw, rdst, m2r, rw, asa, asb, psrc, aop, ill};
    endfunction

    // One cycle: drive at posedge+1, check at negedge, return at next posedge+1
    task automatic step(input int st, input logic mr, input logic [5:0] opv);
        bus.memready = mr;
        bus.op       = opv;
        @(negedge clk);
        chk("state", 32'(bus.state), 32'(st));
        chk($sformatf("ctl_s%0d", st), 32'(ctl_vec), 32'(exp_ctl(st, mr, opv, reset)));
        @(posedge clk);
        #1;
    endtask

    // Expected trace for one instruction with nf FETCH stalls and nm memory stalls
    task automatic run_instr(input logic [5:0] opv, input int nf, input int nm);
        int q[$];
        int st;
        logic mr;
        logic [5:0] drv_op;
        for (int i = 0; i <= nf; i++) q.push_back(ST_FETCH);
        q.push_back(ST_DECODE);
        case (op_kind(opv))
            0: begin q.push_back(ST_EXECUTE); q.push_back(ST_ALUWB); end
            1: begin
                q.push_back(ST_MEMADR);
                for (int i = 0; i <= nm; i++) q.push_back(ST_MEMRD);
                q.push_back(ST_MEMWB);
            end
            2: begin
                q.push_back(ST_MEMADR);
                for (int i = 0; i <= nm; i++) q.push_back(ST_MEMWR);
            end
            3: q.push_back(ST_BRANCH);
            4: begin q.push_back(ST_ADDIEXEC); q.push_back(ST_ADDIWB); end
            5: q.push_back(ST_JUMP);
            default: ;
        endcase
        for (int i = 0; i < q.size(); i++) begin
            st = q[i];
            if (st == ST_FETCH || st == ST_MEMRD || st == ST_MEMWR)
                mr = (i == q.size() - 1) || (q[i + 1] != st);
            else
                mr = 1'($urandom);
            drv_op = (st == ST_FETCH) ? 6'($urandom) : opv;
            step(st, mr, drv_op);
        end
    endtask

    initial begin
        logic [5:0] rop;
        bus.op       = 6'd0;
        bus.memready = 1'b1;
        reset        = 1'b1;
        #1;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_irwrite", 32'(bus.irwrite), 32'd0);
        chk("rst_pcwrite", 32'(bus.pcwrite), 32'd0);
        @(posedge clk);
        #1;
        step(ST_FETCH, 1'b1, 6'd0);
        reset = 1'b0;

        run_instr(6'b000000, 0, 0);
        run_instr(6'b100011, 2, 3);
        run_instr(6'b101011, 0, 1);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 0, 0);
        run_instr(6'b111111, 1, 0);

        // Asynchronous reset between edges while a store is stalled
        step(ST_FETCH, 1'b1, 6'd5);
        step(ST_DECODE, 1'b1, 6'b101011);
        step(ST_MEMADR, 1'b1, 6'b101011);
        bus.memready = 1'b0;
        #2;
        chk("pre_rst_state", 32'(bus.state), 32'd5);
        chk("pre_rst_memwrite", 32'(bus.memwrite), 32'd1);
        reset = 1'b1;
        bus.memready = 1'b1;
        #1;
        chk("async_state", 32'(bus.state), 32'd0);
        chk("async_memwrite", 32'(bus.memwrite), 32'd0);
        chk("async_irwrite", 32'(bus.irwrite), 32'd0);
        @(posedge clk);
        #1;
        step(ST_FETCH, 1'b1, 6'b101011);
        reset = 1'b0;
        run_instr(6'b001000, 0, 0);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 7))
                0: rop = 6'b000000;
                1: rop = 6'b100011;
                2: rop = 6'b101011;
                3: rop = 6'b000100;
                4: rop = 6'b001000;
                5: rop = 6'b000010;
                default: rop = 6'($urandom);
            endcase
            run_instr(rop, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
